// File: rtl/conv_engine_p_if.sv
// Sample/result bundle for conv_engine_p.
// master = producer/consumer side, slave = engine side.
// Ports: IN_VALID, MODE, IN_A, IN_B (to engine);
//        OUT_VALID, OUT and BUSY if CONV_BUSY_EN (from engine).
interface conv_engine_p_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic                     IN_VALID;
    logic [1:0]               MODE;
    logic signed [DATA_W-1:0] IN_A;
    logic signed [DATA_W-1:0] IN_B;
    logic                     OUT_VALID;
    logic signed [ACC_W-1:0]  OUT;
`ifdef CONV_BUSY_EN
    logic                     BUSY;

    modport master (
        output IN_VALID, MODE, IN_A, IN_B,
        input  OUT_VALID, OUT, BUSY
    );
    modport slave (
        input  IN_VALID, MODE, IN_A, IN_B,
        output OUT_VALID, OUT, BUSY
    );
`else
    modport master (
        output IN_VALID, MODE, IN_A, IN_B,
        input  OUT_VALID, OUT
    );
    modport slave (
        input  IN_VALID, MODE, IN_A, IN_B,
        output OUT_VALID, OUT
    );
`endif
endinterface

// File: rtl/conv_engine_p.sv
// Serial signed conv / circular conv / correlation engine, one MAC per cycle.
// Ports: CLK, RESET (sync, active high), io (conv_engine_p_if.slave):
//   IN_VALID/MODE/IN_A/IN_B burst in, OUT_VALID/OUT stream out.
// Optional macro CONV_BUSY_EN adds io.BUSY (high while a frame is in flight).
module conv_engine_p #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16,
    parameter int ACC_W   = 20
) (
    input  logic           CLK,
    input  logic           RESET,
    conv_engine_p_if.slave io
);
    localparam int CW   = $clog2(MAX_LEN + 1);
    localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int NACC = 2 * MAX_LEN - 1;
    localparam int AW   = (NACC > 1) ? $clog2(NACC) : 1;
    localparam int PW   = 2 * DATA_W;

    localparam logic [1:0] MODE_CIRC = 2'd1;
    localparam logic [1:0] MODE_CORR = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CALC,
        S_FIN,
        S_OUTPUT
    } state_e;

    state_e state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [CW-1:0] n_q, n_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic [AW-1:0] oidx_q, oidx_d;
    logic          out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_q, out_d;

    logic signed [DATA_W-1:0] a_q [MAX_LEN];
    logic signed [DATA_W-1:0] a_d [MAX_LEN];
    logic signed [DATA_W-1:0] b_q [MAX_LEN];
    logic signed [DATA_W-1:0] b_d [MAX_LEN];
    logic signed [ACC_W-1:0]  acc_q [NACC];
    logic signed [ACC_W-1:0]  acc_d [NACC];

    logic [IW-1:0] n_last;
    logic [AW-1:0] sum;
    logic [AW-1:0] k;
    logic [AW-1:0] len;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        n_d         = n_q;
        i_d         = i_q;
        j_d         = j_q;
        oidx_d      = oidx_q;
        out_valid_d = 1'b0;
        out_d       = '0;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;

        n_last = IW'(n_q - CW'(1));
        sum    = AW'(i_q) + AW'(j_q);

        // Output length: N for circular, 2N-1 otherwise.
        if (mode_q == MODE_CIRC) begin
            len = AW'(n_q);
        end else begin
            len = AW'(n_q) + AW'(n_q) - AW'(1);
        end

        // i+j < 2N-1, so one conditional subtract gives mod N.
        case (mode_q)
            MODE_CIRC: k = (sum >= AW'(n_q)) ? sum - AW'(n_q) : sum;
            MODE_CORR: k = AW'(i_q) + AW'(n_q) - AW'(1) - AW'(j_q);
            default:   k = sum;
        endcase

        prod     = PW'(a_q[i_q]) * PW'(b_q[j_q]);
        prod_ext = ACC_W'(prod);

        case (state_q)
            S_IDLE: begin
                if (io.IN_VALID) begin
                    a_d[0]  = io.IN_A;
                    b_d[0]  = io.IN_B;
                    n_d     = CW'(1);
                    mode_d  = (io.MODE == 2'd3) ? 2'd0 : io.MODE;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (io.IN_VALID) begin
                    // Beats past MAX_LEN are dropped; N saturates.
                    if (n_q < CW'(MAX_LEN)) begin
                        a_d[n_q[IW-1:0]] = io.IN_A;
                        b_d[n_q[IW-1:0]] = io.IN_B;
                        n_d = n_q + CW'(1);
                    end
                end else begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d[k] = acc_q[k] + prod_ext;
                if (j_q == n_last) begin
                    j_d = '0;
                    if (i_q == n_last) begin
                        state_d = S_FIN;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            S_FIN: begin
                oidx_d  = '0;
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                out_valid_d = 1'b1;
                out_d       = acc_q[oidx_q];
                if (oidx_q == len - AW'(1)) begin
                    for (int m = 0; m < NACC; m++) begin
                        acc_d[m] = '0;
                    end
                    state_d = S_IDLE;
                end else begin
                    oidx_d = oidx_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            n_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            oidx_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int m = 0; m < MAX_LEN; m++) begin
                a_q[m] <= '0;
                b_q[m] <= '0;
            end
            for (int m = 0; m < NACC; m++) begin
                acc_q[m] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            n_q         <= n_d;
            i_q         <= i_d;
            j_q         <= j_d;
            oidx_q      <= oidx_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
        end
    end

    assign io.OUT_VALID = out_valid_q;
    assign io.OUT       = out_q;

`ifdef CONV_BUSY_EN
    // The last OUT_VALID cycle is already in IDLE; keep BUSY through it.
    assign io.BUSY = (state_q != S_IDLE) || out_valid_q;
`endif

endmodule
